// File: rtl/add_share_arb_pkg.sv
// Shared types for the add_share_arb slice: operation tag and the
// round-robin pointer advance used by the arbiter.
package add_share_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = $clog2(MAX_NREQ);

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;

  // Pointer moves to the requester after the one just granted, wrapping at nreq.
  function automatic idx_t next_ptr(input idx_t g, input int unsigned nreq);
    if (32'(g) + 32'd1 >= nreq) return '0;
    return g + idx_t'(1);
  endfunction

endpackage

// File: rtl/add_share_arb_if.sv
// Requester-facing operand and result handshakes of the shared adder.
interface add_share_arb_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 2
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*W-1:0]       req_a;
  logic [NREQ*W-1:0]       req_b;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [NREQ*(W+1)-1:0]   rsp_sum;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum
  );

endinterface

// File: rtl/add_share_arb_pipe.sv
// Pipelined unsigned adder: combinational W-bit add with full carry-out,
// followed by LAT register stages.
module add_pipe #(
  parameter int unsigned W   = 2,
  parameter int unsigned LAT = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  logic [W:0] st [LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < LAT; s++) st[s] <= '0;
    end else begin
      st[0] <= {1'b0, a} + {1'b0, b};
      for (int unsigned s = 1; s < LAT; s++) st[s] <= st[s-1];
    end
  end

  assign sum = st[LAT-1];

endmodule

// File: rtl/add_share_arb.sv
// Round-robin sharing of one pipelined adder among NREQ requesters; a tag
// pipe routes each sum back to the result slot of the requester that issued it.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 2,
  parameter int unsigned LAT  = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  add_share_arb_if.slave bus,
  output logic           idle
);

  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] rvld;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  idx_t            ptr;
  idx_t            gidx;
  logic            gvalid;
  int unsigned     arb_d;
  int unsigned     arb_best;

  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W:0]      sum_out;

  tag_t            tags [LAT];
  tag_t            tag_out;
  logic [W:0]      slot [NREQ];

  assign elig = bus.req_valid & ~busy;

  // Winner is the eligible requester at the smallest rotated distance from ptr.
  // Grants are held off while reset is asserted so req_ready reads 0 in reset.
  always_comb begin
    gvalid   = 1'b0;
    gidx     = '0;
    arb_d    = 0;
    arb_best = NREQ;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_d = i + NREQ - 32'(ptr);
      if (arb_d >= NREQ) arb_d = arb_d - NREQ;
      if (reset_n && elig[i] && (arb_d < arb_best)) begin
        arb_best = arb_d;
        gidx     = idx_t'(i);
        gvalid   = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gvalid && (gidx == idx_t'(i))) begin
        grant[i] = 1'b1;
        a_sel    = bus.req_a[i*W +: W];
        b_sel    = bus.req_b[i*W +: W];
      end
    end
  end

  add_pipe #(
    .W   (W),
    .LAT (LAT)
  ) u_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .a       (a_sel),
    .b       (b_sel),
    .sum     (sum_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < LAT; s++) tags[s] <= '0;
    end else begin
      tags[0] <= '{valid: gvalid, idx: gidx};
      for (int unsigned s = 1; s < LAT; s++) tags[s] <= tags[s-1];
    end
  end

  assign tag_out = tags[LAT-1];

  // A requester never has a grant and a completing result in the same cycle,
  // so the set/clear priorities below never actually compete.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      rvld <= '0;
      ptr  <= '0;
      for (int unsigned i = 0; i < NREQ; i++) slot[i] <= '0;
    end else begin
      if (gvalid) ptr <= next_ptr(gidx, NREQ);
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i])
          busy[i] <= 1'b1;
        else if (rvld[i] && bus.rsp_ready[i])
          busy[i] <= 1'b0;

        if (tag_out.valid && (tag_out.idx == idx_t'(i))) begin
          slot[i] <= sum_out;
          rvld[i] <= 1'b1;
        end else if (rvld[i] && bus.rsp_ready[i]) begin
          rvld[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rvld;
  assign idle          = ~|busy;

  always_comb begin
    bus.rsp_sum = '0;
    for (int unsigned i = 0; i < NREQ; i++) bus.rsp_sum[i*(W+1) +: W+1] = slot[i];
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb: vector table for single-op/contention/reset,
// plus sequences for fairness, backpressure, mid-flight reset and LAT=3.
module tb_add_share_arb;

  logic clock = 1'b0;
  logic reset_n;
  logic idle;
  logic idle3;

  always #5 clock = ~clock;

  add_share_arb_if #(.NREQ(2), .W(2)) bus ();
  add_share_arb_if #(.NREQ(2), .W(2)) bus3 ();

  add_share_arb #(.NREQ(2), .W(2), .LAT(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .idle    (idle)
  );

  add_share_arb #(.NREQ(2), .W(2), .LAT(3)) dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus3),
    .idle    (idle3)
  );

  typedef struct {
    logic       rst;
    logic [1:0] vld;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] rrdy;
    logic [1:0] rdy;
    logic [1:0] rvld;
    logic [5:0] mask;
    logic [5:0] sum;
    logic       idl;
  } vec_t;

  vec_t tbl [10];
  int total = 0;
  int bad   = 0;
  int grants;
  int done1;
  logic [1:0] g;
  logic [1:0] last;

  function automatic vec_t mk(input logic rst, input logic [1:0] vld, input logic [3:0] a,
                              input logic [3:0] b, input logic [1:0] rrdy, input logic [1:0] rdy,
                              input logic [1:0] rvld, input logic [5:0] mask, input logic [5:0] sum,
                              input logic idl);
    vec_t v;
    v.rst = rst; v.vld = vld; v.a = a; v.b = b; v.rrdy = rrdy;
    v.rdy = rdy; v.rvld = rvld; v.mask = mask; v.sum = sum; v.idl = idl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] r);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = r;
  endtask

  task automatic drive3(input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] r);
    bus3.req_valid = v;
    bus3.req_a     = a;
    bus3.req_b     = b;
    bus3.rsp_ready = r;
  endtask

  // Leaves the caller at a falling edge with reset just released: cycle 0 starts here.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drive1(2'b00, 4'h0, 4'h0, 2'b11);
    drive3(2'b00, 4'h0, 4'h0, 2'b11);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    drive1(2'b11, 4'b1111, 4'b1111, 2'b11);
    drive3(2'b00, 4'h0, 4'h0, 2'b11);
    @(negedge clock);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_rvalid", 32'(bus.rsp_valid), 0);
    chk("rst_sum", 32'(bus.rsp_sum), 0);
    chk("rst_idle", 32'(idle), 1);

    //          rst  vld    a        b        rrdy   rdy    rvld   mask       sum        idle
    tbl[0] = mk(0, 2'b01, 4'b0011, 4'b0011, 2'b11, 2'b01, 2'b00, 6'b000000, 6'b000000, 1);
    tbl[1] = mk(0, 2'b00, 4'b0011, 4'b0011, 2'b11, 2'b00, 2'b00, 6'b000000, 6'b000000, 0);
    tbl[2] = mk(0, 2'b00, 4'b0011, 4'b0011, 2'b11, 2'b00, 2'b01, 6'b000111, 6'b000110, 0);
    tbl[3] = mk(0, 2'b00, 4'b0011, 4'b0011, 2'b11, 2'b00, 2'b00, 6'b000000, 6'b000000, 1);
    tbl[4] = mk(1, 2'b00, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 6'b111111, 6'b000000, 1);
    tbl[5] = mk(0, 2'b11, 4'b1001, 4'b1010, 2'b11, 2'b01, 2'b00, 6'b111111, 6'b000000, 1);
    tbl[6] = mk(0, 2'b10, 4'b1001, 4'b1010, 2'b11, 2'b10, 2'b00, 6'b000000, 6'b000000, 0);
    tbl[7] = mk(0, 2'b00, 4'b1001, 4'b1010, 2'b11, 2'b00, 2'b01, 6'b000111, 6'b000011, 0);
    tbl[8] = mk(0, 2'b00, 4'b1001, 4'b1010, 2'b11, 2'b00, 2'b10, 6'b111000, 6'b100000, 0);
    tbl[9] = mk(0, 2'b00, 4'b1001, 4'b1010, 2'b11, 2'b00, 2'b00, 6'b000000, 6'b000000, 1);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      reset_n = ~tbl[i].rst;
      drive1(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].rrdy);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_rvalid", i), 32'(bus.rsp_valid), 32'(tbl[i].rvld));
      chk($sformatf("vec%0d_sum", i), 32'(bus.rsp_sum & tbl[i].mask), 32'(tbl[i].sum & tbl[i].mask));
      chk($sformatf("vec%0d_idle", i), 32'(idle), 32'(tbl[i].idl));
    end

    // Fairness: both requesters always valid; sums 1+1=2 and 3+2=5.
    do_reset();
    grants = 0;
    last   = 2'b00;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clock);
      drive1(2'b11, 4'b1101, 4'b1001, 2'b11);
      #1;
      g = bus.req_ready;
      chk("fair_onehot", 32'($onehot0(g)), 1);
      if (g != 2'b00) begin
        if (last != 2'b00) chk("fair_alt", 32'(g == last), 0);
        last = g;
        grants++;
      end
      if (bus.rsp_valid[0]) chk("fair_sum0", 32'(bus.rsp_sum[2:0]), 2);
      if (bus.rsp_valid[1]) chk("fair_sum1", 32'(bus.rsp_sum[5:3]), 5);
    end
    chk("fair_count", 32'(grants), 20);

    // Backpressure on requester 0 (2+3=5) while requester 1 (1+1=2) keeps flowing.
    do_reset();
    drive1(2'b11, 4'b0110, 4'b0111, 2'b10);
    #1;
    chk("bp_c0_ready", 32'(bus.req_ready), 32'(2'b01));
    @(negedge clock);
    #1;
    chk("bp_c1_ready", 32'(bus.req_ready), 32'(2'b10));
    done1 = 0;
    for (int c = 2; c < 12; c++) begin
      @(negedge clock);
      #1;
      chk("bp_rvalid0", 32'(bus.rsp_valid[0]), 1);
      chk("bp_sum0", 32'(bus.rsp_sum[2:0]), 5);
      chk("bp_ready0", 32'(bus.req_ready[0]), 0);
      if (bus.rsp_valid[1]) begin
        chk("bp_sum1", 32'(bus.rsp_sum[5:3]), 2);
        done1++;
      end
    end
    chk("bp_done1", 32'(done1), 3);
    @(negedge clock);
    bus.rsp_ready = 2'b11;
    #1;
    chk("bp_c12_ready", 32'(bus.req_ready), 32'(2'b00));
    @(negedge clock);
    #1;
    chk("bp_c13_ready", 32'(bus.req_ready), 32'(2'b01));

    // Reset one cycle after a grant: everything in flight is dropped.
    do_reset();
    drive1(2'b01, 4'b0001, 4'b0001, 2'b11);
    #1;
    chk("mid_grant", 32'(bus.req_ready), 32'(2'b01));
    @(negedge clock);
    reset_n = 1'b0;
    drive1(2'b00, 4'b0000, 4'b0000, 2'b11);
    #1;
    chk("mid_ready", 32'(bus.req_ready), 0);
    chk("mid_rvalid", 32'(bus.rsp_valid), 0);
    chk("mid_sum", 32'(bus.rsp_sum), 0);
    chk("mid_idle", 32'(idle), 1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      chk("mid_no_stale", 32'(bus.rsp_valid), 0);
    end

    // LAT=3 instance: 2+1 handshake in cycle 0, result visible from cycle 4.
    do_reset();
    drive3(2'b01, 4'b0010, 4'b0001, 2'b11);
    #1;
    chk("lat3_grant", 32'(bus3.req_ready), 32'(2'b01));
    for (int c = 1; c < 4; c++) begin
      @(negedge clock);
      drive3(2'b00, 4'b0000, 4'b0000, 2'b11);
      #1;
      chk("lat3_early", 32'(bus3.rsp_valid), 0);
    end
    @(negedge clock);
    #1;
    chk("lat3_rvalid", 32'(bus3.rsp_valid), 32'(2'b01));
    chk("lat3_sum", 32'(bus3.rsp_sum[2:0]), 3);
    @(negedge clock);
    #1;
    chk("lat3_idle", 32'(idle3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
